// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational 32-bit ALU among NUM_REQ requesters.
// Round-robin grant in IDLE, operands registered for one EXEC cycle, registered
// result held in RESP until the consumer handshakes. One operation in flight.
// Optional build macro ALU_ARB_OPCHK_EN: opcodes 5..7 are still accepted, but the
// ALU sees opcode 0 and the response carries result 0 with resp_err set.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [3*NUM_REQ-1:0]   req_op,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [2:0]             alu_op,
    input  logic [31:0]            alu_result,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [31:0]            resp_result,
    output logic                   resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [31:0]       resp_result_q, resp_result_d;
    logic              resp_err_q, resp_err_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_id;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic [2:0]        sel_op;
    logic              op_illegal;

    // Round-robin search: first valid at or above rr_ptr, else first valid from 0 (wrap).
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(i);
            end
        end
    end

    // Operand mux for the granted requester and the one-hot ready (only in IDLE, never in reset).
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_id) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[3*i +: 3];
                req_ready[i] = rst_n && (state_q == IDLE) && gnt_found;
            end
        end
    end

    // Opcode check; the ALU inputs come straight from registers so they never glitch.
    always_comb begin
`ifdef ALU_ARB_OPCHK_EN
        op_illegal = (op_q > 3'd4);
        alu_op     = op_illegal ? 3'd0 : op_q;
`else
        op_illegal = 1'b0;
        alu_op     = op_q;
`endif
        alu_a = a_q;
        alu_b = b_q;
    end

    // Next-state and register updates for the IDLE -> EXEC -> RESP handshake sequence.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        id_d          = id_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_err_d    = resp_err_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    id_d    = gnt_id;
                    rr_ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_result_d = op_illegal ? 32'd0 : alu_result;
                resp_err_d    = op_illegal;
                resp_id_d     = id_q;
                resp_valid_d  = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            id_q          <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            id_q          <= id_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: table vectors, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int N    = 2;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [3*N-1:0]    req_op;
    logic [31:0]       alu_a, alu_b, alu_result;
    logic [2:0]        alu_op;
    logic              resp_valid, resp_ready, resp_err;
    logic [ID_W-1:0]   resp_id;
    logic [31:0]       resp_result;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result), .resp_err(resp_err)
    );

    // Plain ALU behaviour; undefined opcodes return a^b so they are distinguishable.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    // The bench plays the shared ALU.
    always_comb alu_result = ref_alu(alu_op, alu_a, alu_b);

    function automatic logic [31:0] exp_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_ARB_OPCHK_EN
        if (op > 3'd4) return 32'd0;
`endif
        return ref_alu(op, a, b);
    endfunction

    function automatic logic exp_err(input logic [2:0] op);
`ifdef ALU_ARB_OPCHK_EN
        return op > 3'd4;
`else
        return (op > 3'd7);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[3*i +: 3]  = op;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a0, b0;
        logic [2:0]  op0;
        logic [31:0] a1, b1;
        logic [2:0]  op1;
        int          exp_g;
        logic [31:0] exp_r;
        logic        exp_e;
    } vec_t;

    vec_t vecs[9];

    // One full transaction: grant, EXEC, RESP with resp_ready high.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid  = v.valid;
        set_req(0, v.a0, v.b0, v.op0);
        set_req(1, v.a1, v.b1, v.op1);
        resp_ready = 1'b1;
        #1 chk("vec_grant", 32'(req_ready), 32'(1) << v.exp_g);
        @(negedge clk);
        req_valid = '0;
        #1 chk("vec_exec_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("vec_resp_valid", 32'(resp_valid), 32'd1);
        chk("vec_resp_id", 32'(resp_id), 32'(v.exp_g));
        chk("vec_resp_result", resp_result, v.exp_r);
        chk("vec_resp_err", 32'(resp_err), 32'(v.exp_e));
    endtask

    // Randomized-run state: requesters and the transaction-level model.
    logic        pend[N];
    logic [31:0] ra[N], rb[N];
    logic [2:0]  rop[N];
    int          m_rr, m_phase, m_id;
    logic [31:0] m_res;
    logic        m_err;

    function automatic logic [31:0] rnd_val();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int g;
        logic found;
        logic [N-1:0] exp_rdy;

        // Table of single transactions (round-robin pointer history is accounted for in exp_g).
        vecs[0] = '{2'b01, 32'd5, 32'd7, 3'd2, 32'd0, 32'd0, 3'd0, 0, 32'd12, 1'b0};
        vecs[1] = '{2'b11, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'd0, 32'h00FF_00FF, 32'h0F00_0000, 3'd1, 1, 32'h0FFF_00FF, 1'b0};
        vecs[2] = '{2'b11, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'd0, 32'h00FF_00FF, 32'h0F00_0000, 3'd1, 0, 32'h0F0F_0000, 1'b0};
        vecs[3] = '{2'b01, 32'h7FFF_FFFF, 32'd1, 3'd2, 32'd0, 32'd0, 3'd0, 0, 32'h8000_0000, 1'b0};
        vecs[4] = '{2'b10, 32'd0, 32'd0, 3'd0, 32'd0, 32'd1, 3'd3, 1, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{2'b10, 32'd0, 32'd0, 3'd0, 32'hFFFF_FFFF, 32'd2, 3'd4, 1, 32'd1, 1'b0};
        vecs[6] = '{2'b01, 32'd2, 32'hFFFF_FFFF, 3'd4, 32'd0, 32'd0, 3'd0, 0, 32'd0, 1'b0};
`ifdef ALU_ARB_OPCHK_EN
        vecs[7] = '{2'b10, 32'd0, 32'd0, 3'd0, 32'd3, 32'd5, 3'd6, 1, 32'd0, 1'b1};
`else
        vecs[7] = '{2'b10, 32'd0, 32'd0, 3'd0, 32'd3, 32'd5, 3'd6, 1, 32'd6, 1'b0};
`endif
        vecs[8] = '{2'b10, 32'd0, 32'd0, 3'd0, 32'd10, 32'd3, 3'd3, 1, 32'd7, 1'b0};

        // Reset with random inputs on the request side.
        rst_n = 1'b0;
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = N'($urandom);
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            req_op = 6'($urandom);
            resp_ready = 1'($urandom);
            #1;
            chk("reset_resp_valid", 32'(resp_valid), 32'd0);
            chk("reset_req_ready", 32'(req_ready), 32'd0);
            chk("reset_resp_result", resp_result, 32'd0);
        end
        @(negedge clk);
        req_valid = '0;
        resp_ready = 1'b1;
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) run_vec(vecs[v]);

        // Round-robin with both requesters held valid: grants 0,1,0,1.
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (t == 0) begin
                set_req(0, 32'd10, 32'd3, 3'd3);
                set_req(1, 32'hFFFF_FFFF, 32'd2, 3'd4);
                req_valid = 2'b11;
            end
            #1 chk("rr_grant", 32'(req_ready), (t % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            #1 chk("rr_exec_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            #1;
            chk("rr_resp_id", 32'(resp_id), 32'(t % 2));
            chk("rr_resp_result", resp_result, (t % 2 == 0) ? 32'd7 : 32'd1);
        end

        // Backpressure: response held while req1 waits.
        @(negedge clk);
        req_valid = 2'b01;
        set_req(0, 32'd1, 32'd2, 3'd2);
        resp_ready = 1'b0;
        #1 chk("bp_grant0", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b10;
        set_req(1, 32'h0000_00F0, 32'h0000_000F, 3'd1);
        #1 chk("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_result", resp_result, 32'd3);
            chk("bp_hold_id", 32'(resp_id), 32'd0);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        chk("bp_hs_ready", 32'(req_ready), 32'd0);
        chk("bp_hs_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        #1;
        chk("bp_after_valid", 32'(resp_valid), 32'd0);
        chk("bp_after_grant1", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("bp_resp1_id", 32'(resp_id), 32'd1);
        chk("bp_resp1_result", resp_result, 32'h0000_00FF);

        // Reset during EXEC: operation discarded, pointer back to 0.
        @(negedge clk);
        req_valid = 2'b01;
        set_req(0, 32'd9, 32'd1, 3'd2);
        #1 chk("mr_grant0", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("mr_resp_valid", 32'(resp_valid), 32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd0);
        chk("mr_resp_result", resp_result, 32'd0);
        chk("mr_resp_id", 32'(resp_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("mr_no_resp", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1 chk("mr_next_grant0", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("mr_resp_id", 32'(resp_id), 32'd0);
        chk("mr_resp_result", resp_result, 32'd10);

        // Randomized traffic against the transaction-level model.
        m_rr = 1;
        m_phase = 0;
        m_id = 0;
        m_res = '0;
        m_err = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    ra[i] = rnd_val();
                    rb[i] = rnd_val();
                    rop[i] = ($urandom % 10 < 8) ? 3'($urandom % 5) : 3'(5 + $urandom % 3);
                end
                req_valid[i] = pend[i];
                set_req(i, ra[i], rb[i], rop[i]);
            end
            resp_ready = ($urandom % 4 != 0);
            #1;
            exp_rdy = '0;
            found = 1'b0;
            g = 0;
            if (m_phase == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (!found && pend[(m_rr + k) % N]) begin
                        found = 1'b1;
                        g = (m_rr + k) % N;
                    end
                end
                if (found) exp_rdy = N'(1) << g;
            end
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rnd_resp_valid", 32'(resp_valid), (m_phase == 2) ? 32'd1 : 32'd0);
            if (m_phase == 2) begin
                chk("rnd_resp_id", 32'(resp_id), 32'(m_id));
                chk("rnd_resp_result", resp_result, m_res);
                chk("rnd_resp_err", 32'(resp_err), 32'(m_err));
            end
            if (m_phase == 0) begin
                if (found) begin
                    m_id = g;
                    m_res = exp_res(rop[g], ra[g], rb[g]);
                    m_err = exp_err(rop[g]);
                    pend[g] = 1'b0;
                    m_rr = (g + 1) % N;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (resp_ready) begin
                m_phase = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
